// File: rtl/mem_map_pkg.sv
// Data-memory map constants and the bank FSM state type shared by the data scratchpad banks.
package mem_map_pkg;

    localparam logic [31:0] DATA_RAM_START_ADDRESS = 32'h0010_0000;

    typedef logic [0:0] bank_state_t;
    localparam bank_state_t CLEAR = 1'b0;
    localparam bank_state_t READY = 1'b1;

endpackage

// File: rtl/obi_req_if.sv
// OBI request channel: address phase with handshake.
interface obi_req_if;

    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;

    modport master (output req, addr, we, be, wdata, input gnt);
    modport slave  (input req, addr, we, be, wdata, output gnt);

endinterface

// File: rtl/obi_rsp_if.sv
// OBI response channel: read data returned with rvalid.
interface obi_rsp_if;

    logic        rvalid;
    logic [31:0] rdata;

    modport master (output rvalid, rdata);
    modport slave  (input rvalid, rdata);

endinterface

// File: rtl/sram_1rw.sv
// Behavioural single-port SRAM, 32-bit words, byte-enable write, one-cycle synchronous read.
module sram_1rw #(
    parameter int unsigned DEPTH  = 8192,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Contents are deliberately not reset; read data holds across writes.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_bank.sv
// One interleaved data-scratchpad bank: OBI slave over a single-port SRAM,
// with an optional post-reset zero sweep that holds off grants until done.
module data_mem_bank
    import mem_map_pkg::*;
#(
    parameter int unsigned BANK_SIZE_BYTE = 32768,
    parameter int unsigned NUM_BANKS      = 4,
    parameter int unsigned BANK_IDX       = 0,
    parameter logic [31:0] BASE_ADDR      = DATA_RAM_START_ADDRESS,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    obi_req_if.slave  bank_req,
    obi_rsp_if.master bank_rsp,
    output logic      init_done_o,
    output logic      oob_o
);

    localparam int unsigned DEPTH      = BANK_SIZE_BYTE / 4;
    localparam int unsigned ROW_W      = $clog2(DEPTH);
    localparam int unsigned BANK_SHIFT = $clog2(NUM_BANKS);

    if (BANK_IDX >= NUM_BANKS) begin : g_bad_bank_idx
        $error("data_mem_bank: BANK_IDX must be below NUM_BANKS");
    end

    bank_state_t      state_q, state_d;
    logic [ROW_W-1:0] clr_row_q, clr_row_d;
    logic             rvalid_q, rvalid_d;
    logic             rd_q, rd_d;
    logic             oob_q, oob_d;
    logic             init_done_q, init_done_d;

    logic [31:0]      word_c;
    logic [31:0]      row_full_c;
    logic [ROW_W-1:0] row_c;
    logic             oob_c;
    logic             gnt_c;

    logic             sram_en;
    logic             sram_we;
    logic [3:0]       sram_be;
    logic [ROW_W-1:0] sram_addr;
    logic [31:0]      sram_wdata;
    logic [31:0]      sram_rdata;

    // Interleaved decode; bank-select bits are the interconnect's business.
    always_comb begin
        word_c     = (bank_req.addr - BASE_ADDR) >> 2;
        row_full_c = word_c >> BANK_SHIFT;
        row_c      = row_full_c[ROW_W-1:0];
        oob_c      = (bank_req.addr < BASE_ADDR) || (row_full_c >= 32'(DEPTH));
    end

    always_comb begin
        state_d    = state_q;
        clr_row_d  = clr_row_q;
        gnt_c      = 1'b0;
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_be    = 4'h0;
        sram_addr  = row_c;
        sram_wdata = 32'h0;
        rvalid_d   = 1'b0;
        rd_d       = 1'b0;
        oob_d      = 1'b0;

        case (state_q)
            CLEAR: begin
                sram_en   = 1'b1;
                sram_we   = 1'b1;
                sram_be   = 4'hF;
                sram_addr = clr_row_q;
                clr_row_d = clr_row_q + ROW_W'(1);
                if (clr_row_q == ROW_W'(DEPTH - 1)) begin
                    state_d = READY;
                end
            end
            default: begin
                gnt_c      = bank_req.req;
                sram_en    = gnt_c & ~oob_c;
                sram_we    = bank_req.we;
                sram_be    = bank_req.be;
                sram_wdata = bank_req.wdata;
                rvalid_d   = gnt_c;
                rd_d       = gnt_c & ~bank_req.we;
                oob_d      = gnt_c & oob_c;
            end
        endcase

        // A grant coinciding with reset is abandoned, including its write.
        if (rst_i) begin
            sram_en = 1'b0;
        end

        init_done_d = (state_d == READY);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= CLEAR_ON_RESET ? CLEAR : READY;
            clr_row_q   <= '0;
            rvalid_q    <= 1'b0;
            rd_q        <= 1'b0;
            oob_q       <= 1'b0;
            init_done_q <= ~CLEAR_ON_RESET;
        end else begin
            state_q     <= state_d;
            clr_row_q   <= clr_row_d;
            rvalid_q    <= rvalid_d;
            rd_q        <= rd_d;
            oob_q       <= oob_d;
            init_done_q <= init_done_d;
        end
    end

    sram_1rw #(
        .DEPTH  (DEPTH),
        .ADDR_W (ROW_W)
    ) u_sram (
        .clk_i   (clk_i),
        .en_i    (sram_en),
        .we_i    (sram_we),
        .be_i    (sram_be),
        .addr_i  (sram_addr),
        .wdata_i (sram_wdata),
        .rdata_o (sram_rdata)
    );

    assign bank_req.gnt    = gnt_c;
    assign bank_rsp.rvalid = rvalid_q;
    assign bank_rsp.rdata  = (rd_q && !oob_q) ? sram_rdata : 32'h0;
    assign init_done_o     = init_done_q;
    assign oob_o           = oob_q;

endmodule

// File: tb/tb_data_mem_bank.sv
// Randomized self-checking bench for data_mem_bank against an array-based memory model.
module tb_data_mem_bank;

    localparam int unsigned BANK_SIZE_BYTE = 1024;
    localparam int unsigned DEPTH          = BANK_SIZE_BYTE / 4;
    localparam int unsigned NB             = 4;
    localparam int unsigned BIDX           = 2;
    localparam logic [31:0] BASE           = mem_map_pkg::DATA_RAM_START_ADDRESS;
    localparam logic [31:0] OOB_ADDR       = BASE + 32'(4 * NB * DEPTH);

    logic clk;
    logic rst;
    logic init_done;
    logic oob;

    obi_req_if req_if ();
    obi_rsp_if rsp_if ();

    data_mem_bank #(
        .BANK_SIZE_BYTE (BANK_SIZE_BYTE),
        .NUM_BANKS      (NB),
        .BANK_IDX       (BIDX),
        .BASE_ADDR      (BASE),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bank_req    (req_if),
        .bank_rsp    (rsp_if),
        .init_done_o (init_done),
        .oob_o       (oob)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_mem [DEPTH];
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
    logic        exp_oob;
    logic [31:0] last_rdata;
    logic        last_oob;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] row_addr(input int unsigned row);
        return BASE + 32'((row * NB + BIDX) * 4);
    endfunction

    // Reference behaviour: row = byte offset / (4 * banks); out of range below base or past depth.
    task automatic model_access(input logic [31:0] a, input logic w, input logic [3:0] b,
                                input logic [31:0] d, output logic [31:0] rd, output logic o);
        longint unsigned row;
        rd = 32'h0;
        o  = 1'b0;
        if (a < BASE) begin
            o = 1'b1;
        end else begin
            row = longint'(a - BASE) / longint'(4 * NB);
            if (row >= longint'(DEPTH)) begin
                o = 1'b1;
            end else if (w) begin
                for (int i = 0; i < 4; i++) begin
                    if (b[i]) model_mem[row][8*i +: 8] = d[8*i +: 8];
                end
            end else begin
                rd = model_mem[row];
            end
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 32'h0;
        exp_rvalid = 1'b0;
        exp_rdata  = 32'h0;
        exp_oob    = 1'b0;
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d);
        req_if.req   = r;
        req_if.we    = w;
        req_if.addr  = a;
        req_if.be    = b;
        req_if.wdata = d;
    endtask

    // One READY-state cycle: check last cycle's response, then predict this one's.
    task automatic do_cycle(input logic r, input logic w, input logic [31:0] a,
                            input logic [3:0] b, input logic [31:0] d);
        drive(r, w, a, b, d);
        @(negedge clk);
        chk("gnt", 32'(req_if.gnt), 32'(r));
        chk("rvalid", 32'(rsp_if.rvalid), 32'(exp_rvalid));
        chk("oob", 32'(oob), 32'(exp_rvalid & exp_oob));
        if (exp_rvalid) begin
            chk("rdata", rsp_if.rdata, exp_rdata);
            last_rdata = rsp_if.rdata;
            last_oob   = oob;
        end
        exp_rvalid = r;
        exp_rdata  = 32'h0;
        exp_oob    = 1'b0;
        if (r) model_access(a, w, b, d, exp_rdata, exp_oob);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        drive(1'b1, 1'b0, row_addr(0), 4'h0, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_rvalid", 32'(rsp_if.rvalid), 32'h0);
        chk("rst_oob", 32'(oob), 32'h0);
        chk("rst_init_done", 32'(init_done), 32'h0);
        chk("rst_gnt", 32'(req_if.gnt), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_zero();
    endtask

    // Hold a request through the sweep and measure cycles to the first grant.
    task automatic wait_ready(input int unsigned exp_len, input logic w, input logic [31:0] a,
                              input logic [3:0] b, input logic [31:0] d);
        int unsigned n = 0;
        bit seen = 1'b0;
        bit early_done = 1'b0;
        bit stray_rv = 1'b0;
        drive(1'b1, w, a, b, d);
        while (!seen && n < 2 * DEPTH) begin
            @(negedge clk);
            if (req_if.gnt === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (init_done !== 1'b0) early_done = 1'b1;
                if (rsp_if.rvalid !== 1'b0) stray_rv = 1'b1;
                @(posedge clk);
                #1;
                n++;
            end
        end
        chk("clr_cycles", 32'(n), 32'(exp_len));
        chk("clr_init_low", 32'(early_done), 32'h0);
        chk("clr_rvalid_quiet", 32'(stray_rv), 32'h0);
        chk("init_done_rise", 32'(init_done), 32'h1);
        exp_rvalid = 1'b0;
        if (seen) begin
            model_access(a, w, b, d, exp_rdata, exp_oob);
            exp_rvalid = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] a;
        int unsigned row;
        int unsigned kind;

        clk = 1'b0;
        rst = 1'b1;
        drive(1'b0, 1'b0, BASE, 4'h0, 32'h0);
        last_rdata = 32'h0;
        last_oob   = 1'b0;
        model_zero();

        // Clear sweep with a read of row 5 pending from reset release.
        apply_reset();
        wait_ready(DEPTH, 1'b0, row_addr(5), 4'h0, 32'h0);
        do_cycle(1'b0, 1'b0, BASE, 4'h0, 32'h0);
        chk("clear_row5", last_rdata, 32'h0);

        // Byte-masked write to row 2, then read back.
        do_cycle(1'b1, 1'b1, BASE + 32'h28, 4'b0101, 32'hAABB_CCDD);
        do_cycle(1'b0, 1'b0, BASE, 4'h0, 32'h0);
        chk("wr_rsp_rdata", last_rdata, 32'h0);
        do_cycle(1'b1, 1'b0, BASE + 32'h28, 4'h0, 32'h0);
        do_cycle(1'b0, 1'b0, BASE, 4'h0, 32'h0);
        chk("bytemask_rdata", last_rdata, 32'h00BB_00DD);

        // Back-to-back write then read of row 7.
        do_cycle(1'b1, 1'b1, row_addr(7), 4'hF, 32'h1234_5678);
        do_cycle(1'b1, 1'b0, row_addr(7), 4'h0, 32'h0);
        do_cycle(1'b0, 1'b0, BASE, 4'h0, 32'h0);
        chk("b2b_rdata", last_rdata, 32'h1234_5678);

        // Out-of-range read and writes (above depth, below base).
        do_cycle(1'b1, 1'b0, OOB_ADDR, 4'h0, 32'h0);
        do_cycle(1'b1, 1'b1, OOB_ADDR, 4'hF, 32'hFFFF_FFFF);
        chk("oob_read_flag", 32'(last_oob), 32'h1);
        chk("oob_read_rdata", last_rdata, 32'h0);
        do_cycle(1'b1, 1'b1, BASE - 32'h4, 4'hF, 32'hDEAD_BEEF);
        do_cycle(1'b1, 1'b1, row_addr(3), 4'h0, 32'hCAFE_F00D);
        do_cycle(1'b0, 1'b0, BASE, 4'h0, 32'h0);

        // Random traffic, concentrated on few rows to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 19);
            row  = (kind < 12) ? $urandom_range(0, 15) : $urandom_range(0, DEPTH - 1);
            a    = BASE + 32'((row * NB + ((kind % 3 == 0) ? $urandom_range(0, NB - 1) : BIDX)) * 4)
                   + 32'($urandom_range(0, 3));
            if (kind == 18) a = OOB_ADDR + 32'($urandom_range(0, 255) * 4);
            if (kind == 19) a = BASE - 32'($urandom_range(1, 64) * 4);
            do_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a,
                     4'($urandom_range(0, 15)), $urandom);
        end

        // Full readback: every row must match the model.
        for (int r = 0; r < int'(DEPTH); r++) begin
            do_cycle(1'b1, 1'b0, row_addr(r), 4'h0, 32'h0);
        end
        do_cycle(1'b0, 1'b0, BASE, 4'h0, 32'h0);

        // Reset in the same cycle as a granted (out-of-range) read.
        drive(1'b1, 1'b0, OOB_ADDR, 4'h0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrd_gnt", 32'(req_if.gnt), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, BASE, 4'h0, 32'h0);
        model_zero();
        @(negedge clk);
        chk("midrd_no_rvalid", 32'(rsp_if.rvalid), 32'h0);
        chk("midrd_no_oob", 32'(oob), 32'h0);
        @(posedge clk);
        #1;
        wait_ready(DEPTH - 1, 1'b0, row_addr(2), 4'h0, 32'h0);
        do_cycle(1'b0, 1'b0, BASE, 4'h0, 32'h0);

        // Reset mid-sweep at clr_row = 100 restarts the sweep.
        apply_reset();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("sweep_gnt_low", 32'(req_if.gnt), 32'h0);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_zero();
        wait_ready(DEPTH, 1'b0, row_addr(7), 4'h0, 32'h0);
        do_cycle(1'b1, 1'b0, row_addr(DEPTH - 1), 4'h0, 32'h0);
        do_cycle(1'b0, 1'b0, BASE, 4'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_bank.md
# data_mem_bank

One interleaved data-scratchpad bank: an OBI slave that sits directly downstream of the data bus interconnect, one instance per `DATA_MEM_NUM_BANKS` slave port. It decodes the interleaved address into a bank row and serves single-cycle reads and byte-masked writes from a single-port SRAM. Optionally it zero-clears the SRAM after reset and holds off grants until the sweep completes.

## Interface

Parameters:
- `BANK_SIZE_BYTE`, default 32768: bytes per bank. `DEPTH = BANK_SIZE_BYTE/4` words; `ROW_W = $clog2(DEPTH)`.
- `NUM_BANKS`, default 4: interleave factor, a power of two.
- `BANK_IDX`, default 0: this bank's index, 0..NUM_BANKS-1.
- `BASE_ADDR`, default `mem_map_pkg::DATA_RAM_START_ADDRESS`: byte address of word 0 of the interleaved region.
- `CLEAR_ON_RESET`, default 1: run the zero sweep after reset.

Ports:
- `clk_i`, in, 1: clock. Single clock domain.
- `rst_i`, in, 1: reset. Synchronous, active-high.
- `bank_req`, `obi_req_if.slave`, with these members:
  - `req`, in, 1
  - `gnt`, out, 1
  - `addr`, in, 32
  - `we`, in, 1
  - `be`, in, 4
  - `wdata`, in, 32
- `bank_rsp`, `obi_rsp_if.master`, with these members:
  - `rvalid`, out, 1
  - `rdata`, out, 32
- `init_done_o`, out, 1: high once the bank is in `READY`.
- `oob_o`, out, 1: one-cycle pulse, coincident with `rvalid`, for an out-of-range access.

## Operation

Address decode:
- `word = (addr - BASE_ADDR) >> 2`, using 32-bit unsigned wrap.
- `row = word >> log2(NUM_BANKS)`.
- `addr[1:0]` is ignored.
- Bank-select bits are not checked; the interconnect owns routing.
- Out of range: `row >= DEPTH`, or `addr < BASE_ADDR`. A write is dropped. A read returns `rdata = 0`. `oob_o` pulses with that access's `rvalid`.

State machine `bank_state_t`:
- `CLEAR`: the row counter `clr_row` steps 0..DEPTH-1, writing 32'h0 with `be = 4'hF`. `gnt = 0`. When `clr_row == DEPTH-1`, go to `READY`.
- `READY`:
  - `gnt = req` (combinational, no backpressure).
  - A granted write updates the bytes whose `be` bit is set. `be = 0` is a legal no-op write that still gets a response.
  - A granted read captures `row` for the SRAM read.
- Reset sends the FSM to `CLEAR` if `CLEAR_ON_RESET = 1`, else to `READY`.

Requests during `CLEAR`:
- A `req` raised during `CLEAR` stays pending; the master holds it stable per OBI.
- It is granted in the first `READY` cycle.

## Timing

Reset values (at the clock edge where `rst_i` = 1):
- `rvalid = 0`, `oob_o = 0`, `clr_row = 0`.
- `init_done_o = !CLEAR_ON_RESET`.
- `rdata` is don't-care.
- The in-flight response is discarded. SRAM contents are untouched by reset itself.

Clear duration:
- Sweep takes exactly DEPTH cycles.
- With cycle 0 the first cycle `rst_i` is low, the earliest `gnt` is in cycle DEPTH, and `init_done_o` rises in cycle DEPTH.

Response latency:
- A request granted in cycle N gets `rvalid = 1` in cycle N+1, for reads and writes alike.
- `rdata` is valid only while `rvalid` is high. It is 0 for write responses.

Throughput and ordering:
- One transaction per cycle, back-to-back, with no bubbles.
- Responses come in order. At most one is outstanding.

Hazards:
- Read in cycle N+1 of a row written in cycle N returns the new data; the write has completed at edge N+1.
- The single port has no same-cycle read/write conflict.

Reset mid-operation:
- Reset during `CLEAR` restarts the sweep from row 0.
- Reset in `READY` with a grant in the same cycle: that grant produces no response, and a write in that cycle is not performed.

## Structure

- Add `bank_state_t` (`CLEAR`, `READY`) to `mem_map_pkg`. `BASE_ADDR` defaults and region bounds already live there.
- Sub-module `sram_1rw` is a behavioural single-port SRAM:
  - `DEPTH`, 32-bit words, 4-bit byte-enable write.
  - Synchronous read with one-cycle latency.
  - This is the only macro-swap point.
- The FSM, decode and response register stay in `data_mem_bank`.

## Test plan

- Clear sweep: with `CLEAR_ON_RESET = 1`, `req` high from reset release → `gnt` first high in cycle DEPTH, `init_done_o` rises the same cycle. A read of row 5 then returns 32'h0.
- Byte-masked write: bank 2 of 4, write `addr = BASE+0x28` (row 2), `wdata = 32'hAABBCCDD`, `be = 4'b0101`, over 32'h0 → a later read returns 32'h00BB00DD. The write response has `rvalid` one cycle after the grant with `rdata = 0`.
- Back-to-back: write row 7 in cycle N, then read row 7 in cycle N+1 → `rvalid` in N+1 and N+2, and the N+2 `rdata` equals the written value. No `gnt` gap.
- Out of range: read `addr = BASE + 4*NUM_BANKS*DEPTH` → `rdata = 0` and `oob_o = 1` with `rvalid`. An out-of-range write leaves every row unchanged.
- Reset mid-sweep: assert `rst_i` for 1 cycle at `clr_row = 100` → the sweep restarts, and `gnt` is first high DEPTH cycles after the release.
- Reset mid-read: grant a read, and assert `rst_i` in the same cycle → no `rvalid` next cycle, and `oob_o` stays 0.
